dram_responder: RTL
===================

DRAM_RESPONDER -- requirements
Module: dram_responder

Interface
REQ-001 SHALL have parameter ADDR_BITS, default 32, byte-address width.
REQ-002 SHALL have parameter SUB_W, default 64, subblock (beat) width in bits.
REQ-003 SHALL have parameter NSUB_LOG2, default 2, log2 of beats per block.
REQ-004 SHALL have parameter DEPTH_LOG2, default 10, log2 of stored blocks.
REQ-005 SHALL have parameter LATENCY, default 8, access latency in cycles; legal range is 1..255.
REQ-006 SHALL have port clk, input, 1, the single clock; all logic is rising-edge.
REQ-007 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-008 SHALL have port addr, input, ADDR_BITS, block request byte address.
REQ-009 SHALL have port en, input, 1, read-block request, held by the initiator until acc_r.
REQ-010 SHALL have port we, input, 1, write-block request, held by the initiator until acc_w.
REQ-011 SHALL have port wstrb, input, NSUB_LOG2, beat index of wdata.
REQ-012 SHALL have port wdata, input, SUB_W, write beat data.
REQ-013 SHALL have port rstrb, output, NSUB_LOG2, beat index of rdata.
REQ-014 SHALL have port rdata, output, SUB_W, read beat data.
REQ-015 SHALL have port rvalid, output, 1, high during read beats.
REQ-016 SHALL have port acc_r, output, 1, one-cycle read-accept pulse.
REQ-017 SHALL have port acc_w, output, 1, one-cycle write-accept pulse.
REQ-018 SHALL have port ready, output, 1, one-cycle transfer-complete pulse.
REQ-019 SHALL have ports rd_count and wr_count, outputs, 32 each, accepted-request counters.

Function
REQ-020 SHALL implement states IDLE, RLAT, RBURST, WCOLLECT, WLAT, DONE.
REQ-021 SHALL compute block index = addr[BOFF+DEPTH_LOG2-1:BOFF], with BOFF = NSUB_LOG2+log2(SUB_W/8); higher address bits are ignored, so out-of-range addresses alias.
REQ-022 In IDLE with we=1, SHALL latch the index, pulse acc_w next cycle, and enter WCOLLECT; we has priority over a simultaneous en.
REQ-023 In IDLE with en=1 and we=0, SHALL latch the index, pulse acc_r next cycle, and enter RLAT.
REQ-024 SHALL ignore en/we outside IDLE; no accept pulse is issued for them.
REQ-025 WCOLLECT SHALL sample 2^NSUB_LOG2 beats on consecutive cycles, starting the cycle after acc_w, writing wdata into the beat selected by wstrb; a repeated index overwrites.
REQ-026 WLAT and RLAT SHALL each count exactly LATENCY cycles.
REQ-027 RBURST SHALL drive beats 0..N-1 in order, one per cycle, with rvalid=1; the first beat occurs LATENCY cycles after the acc_r cycle.
REQ-028 Outside RBURST, rvalid, rstrb and rdata SHALL be 0.
REQ-029 DONE SHALL pulse ready for one cycle and return to IDLE; the next request is sampled in the following cycle.
REQ-030 A read of a block written earlier SHALL return the written data (read-after-write coherent).

Reset
REQ-031 Asserting reset SHALL immediately force IDLE and drive all outputs to 0, including counters.
REQ-032 Reset mid-transfer SHALL abort it without a ready pulse; the storage array is not reset.

Configuration
REQ-033 With DRAM_STATS_EN defined, rd_count/wr_count SHALL increment on each acc_r/acc_w pulse and saturate at 0xFFFFFFFF.
REQ-034 Without DRAM_STATS_EN, rd_count/wr_count SHALL be constant 0 and no counter flops are inferred.

Verification
REQ-035 Write addr=0x40 with beats 0..3 = 0x11..0x44, then read 0x40 -> acc_w at T+1, ready at T+1+4+8+1; read beats 0x11,0x22,0x33,0x44 with rstrb 0..3.
REQ-036 en=1 and we=1 together in IDLE -> acc_w only; en still held -> acc_r follows immediately after ready.
REQ-037 With LATENCY=8, en at cycle 0 -> acc_r at cycle 1, rvalid on cycles 9..12, ready at cycle 13.
REQ-038 Read addr=0x40 and addr=0x40+2^15 (defaults) -> identical data, confirming alias.
REQ-039 Reset low during RBURST beat 2 -> rvalid=0 and ready=0 at once; a fresh read then completes normally.
REQ-040 With DRAM_STATS_EN, 3 reads and 2 writes -> rd_count=3, wr_count=2; without the macro, both stay 0.

Source files
------------

// File: rtl/dram_responder.sv
// rtl/dram_responder.sv - block-oriented DRAM responder model with fixed access latency
//
// Purpose: stores 2^DEPTH_LOG2 blocks of 2^NSUB_LOG2 beats each. A write request
// collects one beat per cycle after acc_w. A read request streams the block back
// in beat order once LATENCY cycles have elapsed since acc_r.
// Optional feature macro: DRAM_STATS_EN enables the saturating accept counters.
//
// Ports:
//   clk               single rising-edge clock
//   reset             asynchronous active-low reset
//   addr              block request byte address
//   en / we           read / write block request, held until acc_r / acc_w
//   wstrb / wdata     beat index and data of a write beat
//   rstrb / rdata     beat index and data of a read beat (zero outside a burst)
//   rvalid            high during read beats
//   acc_r / acc_w     one-cycle request-accept pulses
//   ready             one-cycle transfer-complete pulse
//   rd_count/wr_count accepted read/write request counters

module dram_responder #(
    parameter int ADDR_BITS  = 32,
    parameter int SUB_W      = 64,
    parameter int NSUB_LOG2  = 2,
    parameter int DEPTH_LOG2 = 10,
    parameter int LATENCY    = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [ADDR_BITS-1:0] addr,
    input  logic                 en,
    input  logic                 we,
    input  logic [NSUB_LOG2-1:0] wstrb,
    input  logic [SUB_W-1:0]     wdata,
    output logic [NSUB_LOG2-1:0] rstrb,
    output logic [SUB_W-1:0]     rdata,
    output logic                 rvalid,
    output logic                 acc_r,
    output logic                 acc_w,
    output logic                 ready,
    output logic [31:0]          rd_count,
    output logic [31:0]          wr_count
);

    localparam int BOFF = NSUB_LOG2 + $clog2(SUB_W / 8);
    localparam int MEM_WORDS = 1 << (DEPTH_LOG2 + NSUB_LOG2);
    localparam logic [NSUB_LOG2-1:0] LAST_BEAT = {NSUB_LOG2{1'b1}};
    localparam logic [7:0] LAT_LOAD = 8'(LATENCY - 1);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] RLAT     = 3'd1;
    localparam logic [2:0] RBURST   = 3'd2;
    localparam logic [2:0] WCOLLECT = 3'd3;
    localparam logic [2:0] WLAT     = 3'd4;
    localparam logic [2:0] DONE     = 3'd5;

    logic [2:0]            state;
    logic [DEPTH_LOG2-1:0] idx;
    logic [NSUB_LOG2-1:0]  beat;
    logic [7:0]            lat_cnt;
    logic [SUB_W-1:0]      mem [0:MEM_WORDS-1];

    logic [DEPTH_LOG2-1:0] req_idx;
    logic                  unused_addr_bits;

    // Bits above the block index are dropped, so out-of-range addresses alias.
    assign req_idx          = addr[BOFF +: DEPTH_LOG2];
    assign unused_addr_bits = ^{addr[ADDR_BITS-1:BOFF+DEPTH_LOG2], addr[BOFF-1:0]};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            idx     <= '0;
            beat    <= '0;
            lat_cnt <= '0;
            acc_r   <= 1'b0;
            acc_w   <= 1'b0;
        end else begin
            acc_r <= 1'b0;
            acc_w <= 1'b0;
            case (state)
                IDLE: begin
                    beat <= '0;
                    if (we) begin
                        idx   <= req_idx;
                        acc_w <= 1'b1;
                        state <= WCOLLECT;
                    end else if (en) begin
                        idx     <= req_idx;
                        acc_r   <= 1'b1;
                        lat_cnt <= LAT_LOAD;
                        state   <= RLAT;
                    end
                end
                WCOLLECT: begin
                    // The acc_w cycle itself carries no beat; sampling starts after it.
                    if (!acc_w) begin
                        beat <= beat + 1'b1;
                        if (beat == LAST_BEAT) begin
                            lat_cnt <= LAT_LOAD;
                            state   <= WLAT;
                        end
                    end
                end
                RLAT, WLAT: begin
                    if (lat_cnt == '0) begin
                        state <= (state == RLAT) ? RBURST : DONE;
                    end else begin
                        lat_cnt <= lat_cnt - 8'd1;
                    end
                end
                RBURST: begin
                    // beat wraps back to zero after the last one
                    beat <= beat + 1'b1;
                    if (beat == LAST_BEAT) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Storage is deliberately left out of reset so data survives an aborted transfer.
    always_ff @(posedge clk) begin
        if (state == WCOLLECT && !acc_w) begin
            mem[{idx, wstrb}] <= wdata;
        end
    end

    assign ready  = (state == DONE);
    assign rvalid = (state == RBURST);
    assign rstrb  = rvalid ? beat : '0;
    assign rdata  = rvalid ? mem[{idx, beat}] : '0;

`ifdef DRAM_STATS_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_count <= '0;
            wr_count <= '0;
        end else begin
            if (acc_r && rd_count != 32'hFFFF_FFFF) begin
                rd_count <= rd_count + 32'd1;
            end
            if (acc_w && wr_count != 32'hFFFF_FFFF) begin
                wr_count <= wr_count + 32'd1;
            end
        end
    end
`else
    assign rd_count = '0;
    assign wr_count = '0;
`endif

endmodule
